run_ctrl: RTL and testbench

RUN_CTRL -- requirements
Module: run_ctrl

---
 rtl/run_ctrl.sv | 128 ++++++++++++
 tb/tb_run_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/run_ctrl.sv
// Run/step/breakpoint controller gating the CPU clock enable.
// Handles single step, free run with limit and breakpoint, and IO acknowledge waits.
module run_ctrl #(
    parameter logic [15:0] RUN_LIMIT = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        step_p,
    input  logic        cont_p,
    input  logic        halt_p,
    input  logic        ent_p,
    input  logic        brk_en,
    input  logic [31:0] brk_addr,
    input  logic [31:0] pc,
    input  logic        io_we,
    input  logic        io_rd,
    output logic        cpu_en,
    output logic        pause,
    output logic        io_wait,
    output logic        brk_hit,
    output logic        lim_hit,
    output logic [15:0] insn_cnt,
    output logic [1:0]  st
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        RUN  = 2'd2,
        IOW  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic        ret_run_q, ret_run_d;
    logic        first_q, first_d;
    logic [15:0] cnt_q, cnt_d;
    logic        brk_hit_q, brk_hit_d;
    logic        lim_hit_q, lim_hit_d;

    logic stop_brk;
    logic stop_lim;
    logic run_stop;
    logic io_acc;

    // first_q masks the breakpoint so a continue from the breakpoint PC advances
    assign stop_brk = brk_en & (pc == brk_addr) & ~first_q;
    assign stop_lim = (cnt_q == RUN_LIMIT);
    assign run_stop = halt_p | stop_brk | stop_lim;
    assign io_acc   = io_we | io_rd;

    always_comb begin
        state_d   = state_q;
        ret_run_d = ret_run_q;
        first_d   = first_q;
        cnt_d     = cnt_q;
        brk_hit_d = 1'b0;
        lim_hit_d = 1'b0;
        cpu_en    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cont_p) begin
                    state_d   = RUN;
                    cnt_d     = 16'd0;
                    first_d   = 1'b1;
                    ret_run_d = 1'b1;
                end else if (step_p) begin
                    state_d   = STEP;
                    cnt_d     = 16'd0;
                    ret_run_d = 1'b0;
                end
            end
            STEP: begin
                cpu_en  = 1'b1;
                state_d = io_acc ? IOW : IDLE;
            end
            RUN: begin
                if (run_stop) begin
                    state_d   = IDLE;
                    brk_hit_d = ~halt_p & stop_brk;
                    lim_hit_d = ~halt_p & stop_lim;
                end else begin
                    cpu_en  = 1'b1;
                    first_d = 1'b0;
                    if (io_acc) begin
                        state_d = IOW;
                    end
                end
            end
            IOW: begin
                if (halt_p) begin
                    ret_run_d = 1'b0;
                end
                if (ent_p) begin
                    state_d = (ret_run_q & ~halt_p) ? RUN : IDLE;
                end
            end
        endcase
        if (cpu_en && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            ret_run_q <= 1'b0;
            first_q   <= 1'b0;
            cnt_q     <= 16'd0;
            brk_hit_q <= 1'b0;
            lim_hit_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ret_run_q <= ret_run_d;
            first_q   <= first_d;
            cnt_q     <= cnt_d;
            brk_hit_q <= brk_hit_d;
            lim_hit_q <= lim_hit_d;
        end
    end

    assign pause    = ~cpu_en;
    assign io_wait  = (state_q == IOW);
    assign brk_hit  = brk_hit_q;
    assign lim_hit  = lim_hit_q;
    assign insn_cnt = cnt_q;
    assign st       = state_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl: directed vector table, hand-written reset sequences and
// randomized stimulus against a behavioural model (DUT A limit 5, DUT B default).
`timescale 1ns/1ps
module tb_run_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        step_p, cont_p, halt_p, ent_p;
    logic        brk_en, io_we, io_rd;
    logic [31:0] brk_addr, pc;

    logic        en_a, pause_a, iow_a, bh_a, lh_a;
    logic [15:0] cnt_a;
    logic [1:0]  st_a;
    logic        en_b, pause_b, iow_b, bh_b, lh_b;
    logic [15:0] cnt_b;
    logic [1:0]  st_b;

    always #5 clk = ~clk;

    run_ctrl #(.RUN_LIMIT(16'd5)) dut_a (
        .clk(clk), .rstn(rstn), .step_p(step_p), .cont_p(cont_p),
        .halt_p(halt_p), .ent_p(ent_p), .brk_en(brk_en),
        .brk_addr(brk_addr), .pc(pc), .io_we(io_we), .io_rd(io_rd),
        .cpu_en(en_a), .pause(pause_a), .io_wait(iow_a),
        .brk_hit(bh_a), .lim_hit(lh_a), .insn_cnt(cnt_a), .st(st_a)
    );

    run_ctrl dut_b (
        .clk(clk), .rstn(rstn), .step_p(step_p), .cont_p(cont_p),
        .halt_p(halt_p), .ent_p(ent_p), .brk_en(brk_en),
        .brk_addr(brk_addr), .pc(pc), .io_we(io_we), .io_rd(io_rd),
        .cpu_en(en_b), .pause(pause_b), .io_wait(iow_b),
        .brk_hit(bh_b), .lim_hit(lh_b), .insn_cnt(cnt_b), .st(st_b)
    );

    wire logic [22:0] obs_a = {st_a, en_a, pause_a, iow_a, bh_a, lh_a, cnt_a};
    wire logic [22:0] obs_b = {st_b, en_b, pause_b, iow_b, bh_b, lh_b, cnt_b};

    int checks = 0;
    int failures = 0;

    // Behavioural model, one slot per DUT; states use the published codes.
    int m_st[2];
    bit m_ret[2];
    bit m_first[2];
    int m_cnt[2];
    bit m_bh[2];
    bit m_lh[2];
    int m_lim[2];

    function automatic void m_reset();
        for (int k = 0; k < 2; k++) begin
            m_st[k] = 0; m_ret[k] = 0; m_first[k] = 0;
            m_cnt[k] = 0; m_bh[k] = 0; m_lh[k] = 0;
        end
    endfunction

    function automatic bit m_issue(int k);
        bit stop;
        if (m_st[k] == 1) return 1'b1;
        if (m_st[k] != 2) return 1'b0;
        stop = halt_p || (brk_en && pc == brk_addr && !m_first[k])
               || (m_cnt[k] == m_lim[k]);
        return !stop;
    endfunction

    function automatic logic [22:0] m_obs(int k);
        bit en;
        en = m_issue(k);
        return {2'(m_st[k]), en, !en, m_st[k] == 3,
                m_bh[k], m_lh[k], 16'(m_cnt[k])};
    endfunction

    function automatic void m_step();
        for (int k = 0; k < 2; k++) begin
            bit en, bpc, lmc, io;
            int nst;
            en  = m_issue(k);
            bpc = brk_en && pc == brk_addr && !m_first[k];
            lmc = m_cnt[k] == m_lim[k];
            io  = io_we || io_rd;
            nst = m_st[k];
            m_bh[k] = 0;
            m_lh[k] = 0;
            case (m_st[k])
                0: begin
                    if (cont_p) begin
                        nst = 2; m_cnt[k] = 0; m_first[k] = 1; m_ret[k] = 1;
                    end else if (step_p) begin
                        nst = 1; m_cnt[k] = 0; m_ret[k] = 0;
                    end
                end
                1: nst = io ? 3 : 0;
                2: begin
                    if (!en) begin
                        nst = 0;
                        if (!halt_p) begin
                            m_bh[k] = bpc;
                            m_lh[k] = lmc;
                        end
                    end else begin
                        m_first[k] = 0;
                        if (io) nst = 3;
                    end
                end
                default: begin
                    if (halt_p) m_ret[k] = 0;
                    if (ent_p) nst = m_ret[k] ? 2 : 0;
                end
            endcase
            if (en && m_cnt[k] < 65535) m_cnt[k]++;
            m_st[k] = nst;
        end
    endfunction

    task automatic check_all();
        logic [22:0] exp, got;
        for (int k = 0; k < 2; k++) begin
            exp = m_obs(k);
            got = (k == 0) ? obs_a : obs_b;
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL model_dut%0d t=%0t got=%h exp=%h (st,en,pause,iow,bh,lh,cnt)",
                         k, $time, got, exp);
            end
        end
    endtask

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
        end
    endtask

    task automatic drive(input logic s, input logic c, input logic h,
                         input logic e, input logic we, input logic rd,
                         input logic [31:0] p);
        step_p = s; cont_p = c; halt_p = h; ent_p = e;
        io_we = we; io_rd = rd; pc = p;
    endtask

    task automatic cycle();
        #1;
        check_all();
        m_step();
        @(negedge clk);
    endtask

    // Reset asserted while clk is low, checked before the next rising edge.
    task automatic reset_mid(string name);
        drive(0, 0, 0, 0, 0, 0, pc);
        #2;
        rstn = 1'b0;
        #1;
        m_reset();
        chk(name, {7'd0, obs_a}, {7'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0});
        check_all();
        @(negedge clk);
        rstn = 1'b1;
    endtask

    typedef struct {
        logic s, c, h, e, we, rd;
        logic [31:0] pc;
        logic [1:0] st;
        logic en, iow, bh, lh;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(logic s, logic c, logic h, logic e, logic we, logic rd,
                       logic [31:0] p, logic [1:0] st, logic en, logic iow,
                       logic bh, logic lh, logic [15:0] cnt);
        vec_t v;
        v.s = s; v.c = c; v.h = h; v.e = e; v.we = we; v.rd = rd; v.pc = p;
        v.st = st; v.en = en; v.iow = iow; v.bh = bh; v.lh = lh; v.cnt = cnt;
        tbl.push_back(v);
    endtask

    task automatic fill_table();
        //  s c h e w r  pc      st en iw bh lh cnt
        add(0,0,0,0,0,0, 32'h00, 0, 0, 0, 0, 0, 0);
        add(0,0,1,1,0,0, 32'h00, 0, 0, 0, 0, 0, 0);
        add(1,0,0,0,0,0, 32'h00, 0, 0, 0, 0, 0, 0);
        add(0,0,0,0,0,0, 32'h00, 1, 1, 0, 0, 0, 0);
        add(0,0,0,0,0,0, 32'h04, 0, 0, 0, 0, 0, 1);
        add(1,1,0,0,0,0, 32'h00, 0, 0, 0, 0, 0, 1);
        add(0,0,0,0,0,0, 32'h00, 2, 1, 0, 0, 0, 0);
        add(0,0,0,0,0,0, 32'h04, 2, 1, 0, 0, 0, 1);
        add(0,0,0,0,1,0, 32'h08, 2, 1, 0, 0, 0, 2);
        add(0,0,0,0,0,0, 32'h0C, 3, 0, 1, 0, 0, 3);
        add(1,1,0,0,0,0, 32'h0C, 3, 0, 1, 0, 0, 3);
        add(0,0,0,1,0,0, 32'h0C, 3, 0, 1, 0, 0, 3);
        add(0,0,0,0,0,0, 32'h0C, 2, 0, 0, 0, 0, 3);
        add(0,0,0,0,0,0, 32'h0C, 0, 0, 0, 1, 0, 3);
        add(0,1,0,0,0,0, 32'h0C, 0, 0, 0, 0, 0, 3);
        add(0,0,0,0,0,0, 32'h0C, 2, 1, 0, 0, 0, 0);
        add(0,0,0,0,0,0, 32'h10, 2, 1, 0, 0, 0, 1);
        add(0,0,0,0,0,0, 32'h14, 2, 1, 0, 0, 0, 2);
        add(0,0,0,0,0,0, 32'h18, 2, 1, 0, 0, 0, 3);
        add(0,0,0,0,0,0, 32'h1C, 2, 1, 0, 0, 0, 4);
        add(0,0,0,0,0,0, 32'h20, 2, 0, 0, 0, 0, 5);
        add(0,0,0,0,0,0, 32'h24, 0, 0, 0, 0, 1, 5);
        add(0,1,0,0,0,0, 32'h40, 0, 0, 0, 0, 0, 5);
        add(0,0,1,0,0,0, 32'h40, 2, 0, 0, 0, 0, 0);
        add(0,0,0,0,0,0, 32'h40, 0, 0, 0, 0, 0, 0);
        add(0,1,0,0,0,0, 32'h0C, 0, 0, 0, 0, 0, 0);
        add(0,0,0,0,0,0, 32'h0C, 2, 1, 0, 0, 0, 0);
        add(0,0,1,0,0,0, 32'h0C, 2, 0, 0, 0, 0, 1);
        add(0,0,0,0,0,0, 32'h0C, 0, 0, 0, 0, 0, 1);
        add(1,0,0,0,0,0, 32'h00, 0, 0, 0, 0, 0, 1);
        add(0,0,0,0,0,1, 32'h00, 1, 1, 0, 0, 0, 0);
        add(0,0,0,0,0,0, 32'h04, 3, 0, 1, 0, 0, 1);
        add(0,0,0,1,0,0, 32'h04, 3, 0, 1, 0, 0, 1);
        add(0,0,0,0,0,0, 32'h04, 0, 0, 0, 0, 0, 1);
        add(0,1,0,0,0,0, 32'h40, 0, 0, 0, 0, 0, 1);
        add(0,0,0,0,1,0, 32'h40, 2, 1, 0, 0, 0, 0);
        add(0,0,1,0,0,0, 32'h44, 3, 0, 1, 0, 0, 1);
        add(0,0,0,1,0,0, 32'h44, 3, 0, 1, 0, 0, 1);
        add(0,0,0,0,0,0, 32'h44, 0, 0, 0, 0, 0, 1);
        add(0,1,0,0,0,0, 32'h40, 0, 0, 0, 0, 0, 1);
        add(0,0,0,0,1,0, 32'h40, 2, 1, 0, 0, 0, 0);
        add(0,0,1,1,0,0, 32'h44, 3, 0, 1, 0, 0, 1);
        add(0,0,0,0,0,0, 32'h44, 0, 0, 0, 0, 0, 1);
        add(0,1,0,0,0,0, 32'h40, 0, 0, 0, 0, 0, 1);
        add(0,0,0,0,1,0, 32'h40, 2, 1, 0, 0, 0, 0);
        add(0,0,0,1,0,0, 32'h44, 3, 0, 1, 0, 0, 1);
        add(0,0,0,0,0,0, 32'h44, 2, 1, 0, 0, 0, 1);
        add(0,0,1,0,0,0, 32'h48, 2, 0, 0, 0, 0, 2);
        add(0,0,0,0,0,0, 32'h48, 0, 0, 0, 0, 0, 2);
    endtask

    task automatic run_table();
        logic [22:0] exp;
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].s, tbl[i].c, tbl[i].h, tbl[i].e,
                  tbl[i].we, tbl[i].rd, tbl[i].pc);
            #1;
            exp = {tbl[i].st, tbl[i].en, ~tbl[i].en, tbl[i].iow,
                   tbl[i].bh, tbl[i].lh, tbl[i].cnt};
            checks++;
            if (obs_a !== exp) begin
                failures++;
                $display("FAIL vec%0d got=%h exp=%h (st,en,pause,iow,bh,lh,cnt)",
                         i, obs_a, exp);
            end
            check_all();
            m_step();
            @(negedge clk);
        end
    endtask

    task automatic directed_seqs();
        // Continue from the breakpoint PC on the unlimited DUT keeps running.
        brk_en = 1'b1;
        brk_addr = 32'h0C;
        drive(0, 1, 0, 0, 0, 0, 32'h0C);
        cycle();
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 0, 0, 0, 0, 32'h0C + 32'(4 * i));
            cycle();
        end
        drive(0, 0, 1, 0, 0, 0, 32'h2C);
        #1;
        chk("contbrk_cnt", {16'd0, cnt_b}, 32'd8);
        chk("contbrk_st", {30'd0, st_b}, 32'd2);
        check_all();
        m_step();
        @(negedge clk);
        // Reset in the middle of a run, then a fresh continue.
        drive(0, 1, 0, 0, 0, 0, 32'h100);
        cycle();
        drive(0, 0, 0, 0, 0, 0, 32'h100);
        cycle();
        drive(0, 0, 0, 0, 0, 0, 32'h104);
        #1;
        chk("prerst_st", {30'd0, st_a}, 32'd2);
        chk("prerst_en", {31'd0, en_a}, 32'd1);
        reset_mid("rst_run");
        for (int i = 0; i < 3; i++) begin
            drive(0, i == 0, 0, 0, 0, 0, 32'h200 + 32'(4 * i));
            cycle();
        end
        drive(0, 0, 0, 0, 0, 0, 32'h208);
        #1;
        chk("postrst_cnt", {16'd0, cnt_a}, 32'd2);
        check_all();
        m_step();
        @(negedge clk);
        // Reset while waiting on an IO acknowledge.
        drive(0, 0, 0, 0, 1, 0, 32'h20C);
        cycle();
        drive(0, 0, 0, 0, 0, 0, 32'h210);
        #1;
        chk("preiow_st", {30'd0, st_a}, 32'd3);
        reset_mid("rst_iow");
    endtask

    task automatic random_phase();
        logic [31:0] p;
        int sel;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 249) == 0) begin
                reset_mid("rst_rand");
            end else begin
                if ($urandom_range(0, 99) == 0)
                    brk_addr = ($urandom_range(0, 1) == 1) ? 32'h0C : 32'h10;
                brk_en = ($urandom_range(0, 3) != 0);
                sel = $urandom_range(0, 3);
                case (sel)
                    0: p = brk_addr;
                    1: p = brk_addr + 32'd4;
                    2: p = pc + 32'd4;
                    default: p = $urandom;
                endcase
                drive($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                      $urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0,
                      $urandom_range(0, 7) == 0, $urandom_range(0, 11) == 0, p);
                cycle();
            end
        end
    endtask

    initial begin
        rstn = 1'b1;
        brk_en = 1'b0;
        brk_addr = 32'h0;
        drive(0, 0, 0, 0, 0, 0, 32'h0);
        m_lim[0] = 5;
        m_lim[1] = 65535;
        #2;
        rstn = 1'b0;
        #1;
        m_reset();
        chk("reset_a", {9'd0, obs_a}, {9'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0});
        check_all();
        @(negedge clk);
        rstn = 1'b1;
        brk_en = 1'b1;
        brk_addr = 32'h0C;
        fill_table();
        run_table();
        directed_seqs();
        random_phase();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
